// File: rtl/initial_module.sv
// Init sequencer: sweeps one BTB/BHT/register-file index per clock after reset and
// presents the matching init data, so the CPU can write one entry per cycle while its init switch is high.
module initial_module #(
  parameter logic [39:0] BTB_INIT_VAL = 40'h0_0000_0000,
  parameter logic [1:0]  BHT_INIT_VAL = 2'b01,
  parameter logic [31:0] SP_INIT_VAL  = 32'h0000_3FFC
) (
  input  logic        clk,
  input  logic        rst_i,
  output logic [7:0]  btb_addr,
  output logic [39:0] btb_init,
  output logic [7:0]  bht_addr,
  output logic [1:0]  bht_init,
  output logic [4:0]  reg_addr,
  output logic [31:0] reg_init
);

  localparam logic [7:0] CNT_MAX  = 8'd255;
  localparam logic [4:0] REG_LAST = 5'd31;
  localparam logic [4:0] REG_SP   = 5'd2;

  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  addr_q;
  logic [4:0]  reg_addr_q, reg_addr_d;
  logic [31:0] reg_init_q, reg_init_d;

  // Outputs are registered from the next count so every bus changes on the same edge as cnt.
  always_comb begin
    cnt_d = cnt_q;
    if (rst_i) begin
      cnt_d = 8'd0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 8'd1;
    end

    reg_addr_d = (cnt_d > 8'd31) ? REG_LAST : cnt_d[4:0];
    reg_init_d = (reg_addr_d == REG_SP) ? SP_INIT_VAL : 32'h0;
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    addr_q     <= cnt_d;
    reg_addr_q <= reg_addr_d;
    reg_init_q <= reg_init_d;
  end

  assign btb_addr = addr_q;
  assign bht_addr = addr_q;
  assign btb_init = BTB_INIT_VAL;
  assign bht_init = BHT_INIT_VAL;
  assign reg_addr = reg_addr_q;
  assign reg_init = reg_init_q;

endmodule

// File: tb/tb_initial_module.sv
// Bench for initial_module: directed reset/sweep/saturation/restart steps plus random reset pulses,
// checked against a model that counts clocks since the last reset.
module tb_initial_module;

  logic        clk;
  logic        rst_i;
  logic [7:0]  btb_addr;
  logic [39:0] btb_init;
  logic [7:0]  bht_addr;
  logic [1:0]  bht_init;
  logic [4:0]  reg_addr;
  logic [31:0] reg_init;

  int vectors;
  int miscompares;
  int k;

  initial_module dut (
    .clk      (clk),
    .rst_i    (rst_i),
    .btb_addr (btb_addr),
    .btb_init (btb_init),
    .bht_addr (bht_addr),
    .bht_init (bht_init),
    .reg_addr (reg_addr),
    .reg_init (reg_init)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  // Model: k = clocks since the last reset edge; the sweep index is k clipped at 255,
  // the register index is k clipped at 31, and only x2 carries non-zero data.
  task automatic step(input logic r);
    int e_addr;
    int e_reg;
    logic [31:0] e_data;
    rst_i = r;
    @(posedge clk);
    #1;
    if (r) k = 0;
    else   k = k + 1;
    e_addr = (k > 255) ? 255 : k;
    e_reg  = (k > 31) ? 31 : k;
    e_data = (e_reg == 2) ? 32'h0000_3FFC : 32'h0;
    check("btb_addr", {32'h0, btb_addr}, 40'(e_addr));
    check("bht_addr", {32'h0, bht_addr}, 40'(e_addr));
    check("reg_addr", {35'h0, reg_addr}, 40'(e_reg));
    check("reg_init", {8'h0, reg_init}, {8'h0, e_data});
    check("btb_init", btb_init, 40'h0);
    check("bht_init", {38'h0, bht_init}, 40'h1);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    k = 0;
    rst_i = 1'b1;

    for (int i = 0; i < 30; i++) step(1'b1);

    for (int i = 0; i < 1000; i++) step(1'b0);

    step(1'b1);
    for (int i = 0; i < 100; i++) step(1'b0);
    step(1'b1);
    for (int i = 0; i < 40; i++) step(1'b0);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
    end

    for (int i = 0; i < 6; i++) begin
      step(1'b1);
      for (int j = 0; j < int'($urandom_range(1, 400)); j++) step(1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
